// File: rtl/ldl_pkg.sv
// ldl_pkg: shared LDL-stage types, default widths and saturation limits.
package ldl_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam int LDL_W    = 16;
    localparam int LDL_FRAC = 8;
    localparam int LDL_TAGW = 8;

    function automatic logic [63:0] sat_pos_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Magnitude of the most negative value; its low w bits are also its two's-complement pattern.
    function automatic logic [63:0] sat_neg_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/ldl_sign_mag.sv
// ldl_sign_mag: splits a signed value into sign and W-bit unsigned magnitude.
module ldl_sign_mag #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    output logic         neg,
    output logic [W-1:0] mag
);

    assign neg = x[W-1];
    assign mag = neg ? -x : x;

endmodule

// File: rtl/ldl_div_feeder.sv
// ldl_div_feeder: signed Q-format front end for the unsigned sequential divider.
// Define LDL_DIV_ROUND_EN for round-half-away-from-zero; default truncates toward zero.
module ldl_div_feeder
    import ldl_pkg::*;
#(
    parameter int W    = LDL_W,
    parameter int FRAC = LDL_FRAC,
    parameter int TAGW = LDL_TAGW,
    parameter int DW   = W + FRAC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_num,
    input  logic [W-1:0]    in_den,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_q,
    output logic [TAGW-1:0] out_tag,
    output logic            out_zero_err,
    output logic            out_sat,
    output logic            div_start,
    output logic [DW-1:0]   div_dividend,
    output logic [DW-1:0]   div_divisor,
    input  logic [DW-1:0]   div_quotient,
    input  logic [DW-1:0]   div_remainder,
    input  logic            div_valid
);

    localparam logic [63:0] POS64 = sat_pos_max(W);
    localparam logic [63:0] NEG64 = sat_neg_min(W);

    state_t         state, next_state;
    logic           sgn, armed, num_neg, den_neg, sat_c;
    logic [W-1:0]   num_mag, den_mag, num_abs, den_abs, q_c;
    logic [DW:0]    mag;

    ldl_sign_mag #(.W(W)) u_num (.x(in_num), .neg(num_neg), .mag(num_abs));
    ldl_sign_mag #(.W(W)) u_den (.x(in_den), .neg(den_neg), .mag(den_abs));

    assign in_ready     = state == IDLE;
    assign out_valid    = state == OUT;
    assign div_start    = state == ISSUE;
    assign div_dividend = {num_mag, {FRAC{1'b0}}};
    assign div_divisor  = {{FRAC{1'b0}}, den_mag};

`ifdef LDL_DIV_ROUND_EN
    assign mag = {1'b0, div_quotient} +
                 {{DW{1'b0}}, ({div_remainder, 1'b0} >= {{(FRAC+1){1'b0}}, den_mag})};
`else
    logic unused_rem;
    assign unused_rem = ^div_remainder;
    assign mag = {1'b0, div_quotient};
`endif

    // Negative results may reach 2^(W-1); positive ones stop at 2^(W-1)-1.
    assign sat_c = sgn ? (mag > NEG64[DW:0]) : (mag > POS64[DW:0]);
    assign q_c   = sat_c ? (sgn ? NEG64[W-1:0] : POS64[W-1:0])
                         : (sgn ? -mag[W-1:0] : mag[W-1:0]);

    always_ff @(posedge clk)
        state <= rst ? IDLE : next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = (in_den == '0) ? OUT : ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (armed && div_valid) next_state = OUT;
            OUT:     if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sgn          <= 1'b0;
            armed        <= 1'b0;
            num_mag      <= '0;
            den_mag      <= '0;
            out_tag      <= '0;
            out_q        <= '0;
            out_zero_err <= 1'b0;
            out_sat      <= 1'b0;
        end else begin
            // The divider's valid is stale in the first WAIT cycle, so only trust it once armed.
            armed <= state == WAIT;
            if (state == IDLE && in_valid) begin
                sgn          <= num_neg ^ den_neg;
                num_mag      <= num_abs;
                den_mag      <= den_abs;
                out_tag      <= in_tag;
                out_zero_err <= in_den == '0;
                out_sat      <= in_den == '0;
                out_q        <= num_neg ? NEG64[W-1:0] : POS64[W-1:0];
            end
            if (state == WAIT && armed && div_valid) begin
                out_q   <= q_c;
                out_sat <= sat_c;
            end
        end
    end

endmodule
